// File: rtl/clock_manager_if.sv
// Bus bundle for clock_manager: PLL lock input, divisor programming port,
// sticky-flag clear, and the registered reset / clock-enable outputs.
interface clock_manager_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              locked_in;
  logic              div_wr;
  logic [SW-1:0]     div_sel;
  logic [DIV_W-1:0]  div_data;
  logic              lock_lost_clr;
  logic              sys_resetn;
  logic [NUM_CH-1:0] ce;
  logic              lock_lost;

  modport master (
    output locked_in, div_wr, div_sel, div_data, lock_lost_clr,
    input  sys_resetn, ce, lock_lost
  );

  modport slave (
    input  locked_in, div_wr, div_sel, div_data, lock_lost_clr,
    output sys_resetn, ce, lock_lost
  );
endinterface

// File: rtl/clock_manager.sv
// Clock manager: waits for a stable, synchronised PLL lock, then releases the
// system reset and produces per-channel clock-enable pulses whose period is
// programmable at run time. Losing lock drops everything and sets a sticky flag.
module clock_manager #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DIV_INIT    = 1
) (
  input  logic             clk,
  input  logic             resetn,
  clock_manager_if.slave   bus
);

  localparam int SW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Counter must be able to hold LOCK_CYCLES itself without wrapping.
  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_INIT);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    RUN       = 2'd2
  } state_e;

  logic              sync1_q;
  logic              lk_q;
  state_e            state_q, state_d;
  logic [LCW-1:0]    lcnt_q, lcnt_d;
  logic              sys_resetn_q;
  logic              lock_lost_q, lock_lost_d;
  logic              run_d;
  logic              run_hold;
  logic              wr_valid;
  logic [NUM_CH-1:0] ce_vec;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= bus.locked_in;
      lk_q    <= sync1_q;
    end
  end

  // Lock FSM next state. COUNT lasts LOCK_CYCLES+1 cycles, so sys_resetn rises
  // LOCK_CYCLES+3 edges after locked_in is first sampled high (two synchroniser
  // edges plus the WAIT_LOCK exit edge).
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lk_q) begin
          state_d = COUNT;
          lcnt_d  = '0;
        end
      end
      COUNT: begin
        if (!lk_q) begin
          state_d = WAIT_LOCK;
          lcnt_d  = '0;
        end else if (lcnt_q == LOCK_LAST) begin
          state_d = RUN;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + LCW'(1);
        end
      end
      RUN: begin
        if (!lk_q) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        lcnt_d  = '0;
      end
    endcase
  end

  assign run_d    = (state_d == RUN);
  assign run_hold = (state_q == RUN) && lk_q;
  assign wr_valid = bus.div_wr && (int'(bus.div_sel) < NUM_CH);

  // Sticky lock-lost flag; a new loss wins over a simultaneous clear.
  always_comb begin
    lock_lost_d = lock_lost_q;
    if (bus.lock_lost_clr) lock_lost_d = 1'b0;
    if ((state_q == RUN) && !lk_q) lock_lost_d = 1'b1;
  end

  // FSM, lock counter, system reset and lock-lost registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= WAIT_LOCK;
      lcnt_q       <= '0;
      sys_resetn_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lcnt_q       <= lcnt_d;
      sys_resetn_q <= run_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] a_q, a_d;
      logic [DIV_W-1:0] p_q, p_d;
      logic [DIV_W-1:0] c_q, c_d;
      logic             ce_q, ce_d;
      logic             hit;
      logic             wrap;

      assign hit  = wr_valid && (bus.div_sel == SW'(gi));
      assign wrap = (c_q == a_q);

      // Divisor bookkeeping and period counter; ce is registered from the
      // next-cycle counter so it is high exactly while C equals A.
      always_comb begin
        p_d = p_q;
        a_d = a_q;
        c_d = '0;
        if (hit) p_d = bus.div_data;
        if (run_hold) begin
          if (wrap) begin
            c_d = '0;
            a_d = hit ? bus.div_data : p_q;
          end else begin
            c_d = c_q + DIV_W'(1);
          end
        end else begin
          a_d = p_q;
        end
        ce_d = run_d && (c_d == a_d);
      end

      // Per-channel state registers.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          a_q  <= DIV_RST;
          p_q  <= DIV_RST;
          c_q  <= '0;
          ce_q <= 1'b0;
        end else begin
          a_q  <= a_d;
          p_q  <= p_d;
          c_q  <= c_d;
          ce_q <= ce_d;
        end
      end

      assign ce_vec[gi] = ce_q;
    end
  endgenerate

  assign bus.sys_resetn = sys_resetn_q;
  assign bus.ce         = ce_vec;
  assign bus.lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_clock_manager.sv
// Self-checking bench for clock_manager (NUM_CH=3, DIV_W=8, LOCK_CYCLES=4,
// DIV_INIT=3). The ce reference tracks, per channel, the cycle of its last
// pulse and the period currently in force; a pulse is due when the distance
// from the last pulse equals that period.
module tb_clock_manager;
  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 4;
  localparam int DIV_INIT    = 3;
  localparam int RISE_NEG    = LOCK_CYCLES + 4; // negedges seen until sys_resetn is high

  logic clk;
  logic resetn;

  clock_manager_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clock_manager #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .DIV_INIT(DIV_INIT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: pending/active divisor, cycle of last pulse, RUN cycle.
  int m_p[NUM_CH];
  int m_a[NUM_CH];
  int m_last[NUM_CH];
  int k;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NUM_CH-1:0] exp_ce();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = ((k - m_last[i]) == (m_a[i] + 1));
    return v;
  endfunction

  task automatic model_update(input bit wr, input int sel, input int data,
                              input logic [NUM_CH-1:0] pulses);
    if (wr && sel < NUM_CH) m_p[sel] = data;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pulses[i]) begin
        m_a[i]    = m_p[i];
        m_last[i] = k;
      end
    end
  endtask

  task automatic start_model();
    for (int i = 0; i < NUM_CH; i++) begin
      m_a[i]    = m_p[i];
      m_last[i] = 0;
    end
    k = 0;
  endtask

  task automatic apply_reset();
    resetn            = 1'b0;
    bus.locked_in     = 1'b0;
    bus.div_wr        = 1'b0;
    bus.div_sel       = '0;
    bus.div_data      = '0;
    bus.lock_lost_clr = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_p[i] = DIV_INIT;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Waits (bounded) for sys_resetn; n is the number of negedges observed.
  task automatic wait_run(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.sys_resetn === 1'b1) break;
    end
  endtask

  task automatic write_div(input int sel, input int data);
    bus.div_wr   = 1'b1;
    bus.div_sel  = 2'(sel);
    bus.div_data = 8'(data);
    @(negedge clk);
    bus.div_wr = 1'b0;
    if (sel < NUM_CH) m_p[sel] = data;
    $display("idle write sel=%0d data=%0d", sel, data);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.locked_in = 1'b0;
    bus.div_wr = 1'b0;
    bus.div_sel = '0;
    bus.div_data = '0;
    bus.lock_lost_clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.sys_resetn !== 1'b0 || bus.ce !== 3'b000 || bus.lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: sys=%b ce=%b lost=%b required 0 000 0",
               bus.sys_resetn, bus.ce, bus.lock_lost);
    end
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.sys_resetn !== 1'b0 || bus.ce !== 3'b000) begin
        n_err++;
        $display("FAIL no_lock_idle: sys=%b ce=%b required 0 000", bus.sys_resetn, bus.ce);
      end
    end
  endtask

  task automatic test_startup();
    int n;
    logic [NUM_CH-1:0] e;
    apply_reset();
    bus.locked_in = 1'b1;
    wait_run(n);
    n_cmp++;
    if (n != RISE_NEG) begin
      n_err++;
      $display("FAIL startup_latency: negedges=%0d required %0d", n, RISE_NEG);
    end
    start_model();
    for (int j = 1; j <= 16; j++) begin
      if (j > 1) @(negedge clk);
      k = j;
      e = exp_ce();
      n_cmp++;
      if (bus.ce !== e || bus.sys_resetn !== 1'b1 || bus.lock_lost !== 1'b0) begin
        n_err++;
        $display("FAIL startup_ce k=%0d: ce=%b sys=%b lost=%b required ce=%b sys=1 lost=0",
                 k, bus.ce, bus.sys_resetn, bus.lock_lost, e);
      end
      model_update(1'b0, 0, 0, e);
    end
  endtask

  task automatic test_glitch();
    int n;
    int pre;
    apply_reset();
    pre = $urandom_range(1, 4);
    bus.locked_in = 1'b1;
    for (int i = 0; i < pre + 3; i++) begin
      if (i == pre) bus.locked_in = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.sys_resetn !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_hold: sys=%b required 0 (step %0d)", bus.sys_resetn, i);
      end
    end
    bus.locked_in = 1'b1;
    wait_run(n);
    $display("glitch after %0d cycles, relock latency %0d", pre, n);
    n_cmp++;
    if (n != RISE_NEG) begin
      n_err++;
      $display("FAIL glitch_latency: negedges=%0d required %0d", n, RISE_NEG);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    logic [NUM_CH-1:0] e;
    apply_reset();
    bus.locked_in = 1'b1;
    wait_run(n);
    start_model();
    for (int j = 1; j <= 6; j++) begin
      if (j > 1) @(negedge clk);
      k = j;
      e = exp_ce();
      n_cmp++;
      if (bus.ce !== e || bus.lock_lost !== 1'b0) begin
        n_err++;
        $display("FAIL loss_pre k=%0d: ce=%b lost=%b required ce=%b lost=0",
                 k, bus.ce, bus.lock_lost, e);
      end
      model_update(1'b0, 0, 0, e);
    end
    bus.locked_in = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.sys_resetn !== 1'b0 || bus.ce !== 3'b000 || bus.lock_lost !== 1'b1) begin
      n_err++;
      $display("FAIL loss_outputs: sys=%b ce=%b lost=%b required 0 000 1",
               bus.sys_resetn, bus.ce, bus.lock_lost);
    end
    bus.locked_in = 1'b1;
    wait_run(n);
    n_cmp++;
    if (n != RISE_NEG || bus.lock_lost !== 1'b1) begin
      n_err++;
      $display("FAIL loss_relock: negedges=%0d lost=%b required %0d lost=1",
               n, bus.lock_lost, RISE_NEG);
    end
    // Second loss with a clear landing on the very edge that sets the flag.
    bus.locked_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.lock_lost_clr = 1'b1;
    @(negedge clk);
    bus.lock_lost_clr = 1'b0;
    n_cmp++;
    if (bus.lock_lost !== 1'b1 || bus.sys_resetn !== 1'b0) begin
      n_err++;
      $display("FAIL loss_set_priority: lost=%b sys=%b required lost=1 sys=0",
               bus.lock_lost, bus.sys_resetn);
    end
    bus.lock_lost_clr = 1'b1;
    @(negedge clk);
    bus.lock_lost_clr = 1'b0;
    n_cmp++;
    if (bus.lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL loss_clear: lost=%b required 0", bus.lock_lost);
    end
    bus.locked_in = 1'b1;
    wait_run(n);
    n_cmp++;
    if (n != RISE_NEG || bus.lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL loss_relock2: negedges=%0d lost=%b required %0d lost=0",
               n, bus.lock_lost, RISE_NEG);
    end
  endtask

  // Scripted writes in RUN: ch1<=0 mid-period, ch2<=1 on its wrap edge,
  // and an out-of-range select that must change nothing.
  task automatic test_div_change();
    int n;
    bit wr;
    int sel, data;
    logic [NUM_CH-1:0] e;
    apply_reset();
    bus.locked_in = 1'b1;
    wait_run(n);
    start_model();
    for (int j = 1; j <= 28; j++) begin
      if (j > 1) @(negedge clk);
      k = j;
      e = exp_ce();
      n_cmp++;
      if (bus.ce !== e || bus.sys_resetn !== 1'b1) begin
        n_err++;
        $display("FAIL div_change k=%0d: ce=%b sys=%b required ce=%b sys=1",
                 k, bus.ce, bus.sys_resetn, e);
      end
      wr = 1'b0; sel = 0; data = 0;
      if (k == 2)  begin wr = 1'b1; sel = 1; data = 0; end
      if (k == 12) begin wr = 1'b1; sel = 2; data = 1; end
      if (k == 17) begin wr = 1'b1; sel = 3; data = 7; end
      if (wr) $display("run write k=%0d sel=%0d data=%0d", k, sel, data);
      bus.div_wr   = wr;
      bus.div_sel  = 2'(sel);
      bus.div_data = 8'(data);
      model_update(wr, sel, data, e);
    end
  endtask

  task automatic test_random_divisors();
    int n;
    bit wr;
    int sel, data;
    logic [NUM_CH-1:0] e;
    apply_reset();
    for (int i = 0; i < NUM_CH; i++) write_div(i, $urandom_range(0, 5));
    write_div(3, $urandom_range(0, 255));
    bus.locked_in = 1'b1;
    wait_run(n);
    start_model();
    for (int j = 1; j <= 80; j++) begin
      if (j > 1) @(negedge clk);
      k = j;
      e = exp_ce();
      n_cmp++;
      if (bus.ce !== e) begin
        n_err++;
        $display("FAIL random_ce k=%0d: ce=%b required %b", k, bus.ce, e);
      end
      wr   = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 3);
      data = $urandom_range(0, 5);
      if (wr) $display("run write k=%0d sel=%0d data=%0d", k, sel, data);
      bus.div_wr   = wr;
      bus.div_sel  = 2'(sel);
      bus.div_data = 8'(data);
      model_update(wr, sel, data, e);
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [NUM_CH-1:0] e;
    apply_reset();
    write_div(0, 0);
    bus.locked_in = 1'b1;
    wait_run(n);
    bus.locked_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.locked_in = 1'b1;
    wait_run(n);
    @(negedge clk);
    n_cmp++;
    if (bus.sys_resetn !== 1'b1 || bus.ce[0] !== 1'b1 || bus.lock_lost !== 1'b1) begin
      n_err++;
      $display("FAIL async_pre: sys=%b ce0=%b lost=%b required 1 1 1",
               bus.sys_resetn, bus.ce[0], bus.lock_lost);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (bus.sys_resetn !== 1'b0 || bus.ce !== 3'b000 || bus.lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: sys=%b ce=%b lost=%b required 0 000 0",
               bus.sys_resetn, bus.ce, bus.lock_lost);
    end
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) m_p[i] = DIV_INIT;
    resetn = 1'b1;
    wait_run(n);
    n_cmp++;
    if (n != RISE_NEG) begin
      n_err++;
      $display("FAIL async_relock: negedges=%0d required %0d", n, RISE_NEG);
    end
    start_model();
    for (int j = 1; j <= 8; j++) begin
      if (j > 1) @(negedge clk);
      k = j;
      e = exp_ce();
      n_cmp++;
      if (bus.ce !== e || bus.lock_lost !== 1'b0) begin
        n_err++;
        $display("FAIL async_ce k=%0d: ce=%b lost=%b required ce=%b lost=0",
                 k, bus.ce, bus.lock_lost, e);
      end
      model_update(1'b0, 0, 0, e);
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.locked_in = 1'b0;
    bus.div_wr = 1'b0;
    bus.div_sel = '0;
    bus.div_data = '0;
    bus.lock_lost_clr = 1'b0;
    k = 0;
    test_reset();
    test_startup();
    test_glitch();
    test_lock_loss();
    test_div_change();
    test_random_divisors();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
